div_clk_monitor: RTL and testbench



---
 rtl/div_clk_monitor.sv | 199 +++++++++++++++++++
 tb/tb_div_clk_monitor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: frequency checker for a (half-)integer divided clock.
// The divided clock is sampled as data in the clk domain. Source-clock cycles
// are counted across EDGES rising edges of the divided clock and compared
// against EXP = DIV_X2*EDGES/2 within +/-TOL.
// Optional feature macro: DIV_MON_MINMAX_EN (tracks smallest/largest window).
module div_clk_monitor #(
  parameter int DIV_X2 = 7,
  parameter int EDGES  = 8,
  parameter int TOL    = 2,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             err_clr,
  input  logic             clk_div_in,
  output logic [CNT_W-1:0] win_cnt,
  output logic             win_valid,
  output logic             freq_err,
  output logic             lock,
  output logic [CNT_W-1:0] win_min,
  output logic [CNT_W-1:0] win_max
);

  localparam int EXP     = DIV_X2 * EDGES / 2;
  localparam int TIMEOUT = 2 * EXP;
  localparam int EW      = (EDGES > 1) ? $clog2(EDGES) : 1;

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LO_LIM    = CNT_W'(EXP - TOL);
  localparam logic [CNT_W-1:0] HI_LIM    = CNT_W'(EXP + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [EW-1:0]    EDGE_LAST = EW'(EDGES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [EW-1:0]    edge_cnt;
  logic [1:0]       good_streak;

  logic s0, s1, s2;
  logic rise;

  logic [CNT_W-1:0] meas;
  logic             win_close;
  logic             win_bad;
  logic             timeout_hit;
  logic             set_err;

  // Two-flop synchroniser plus one delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= clk_div_in;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

  // The closing rise itself counts, so the window length is cyc_cnt + 1
  assign meas      = cyc_cnt + CNT_W'(1);
  assign win_close = en && (state == MEAS) && rise && (edge_cnt == EDGE_LAST);
  assign win_bad   = (meas < LO_LIM) || (meas > HI_LIM);

  // Timeout only when no rise rescues ARM and no close rescues MEAS
  assign timeout_hit = en && (cyc_cnt == TO_LAST) &&
                       (((state == ARM) && !rise) || ((state == MEAS) && !win_close));
  assign set_err = timeout_hit || (win_close && win_bad);

  // Measurement FSM with registered window result, error and lock outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      edge_cnt    <= '0;
      good_streak <= 2'd0;
      win_cnt     <= '0;
      win_valid   <= 1'b0;
      freq_err    <= 1'b0;
      lock        <= 1'b0;
    end else begin
      win_valid <= 1'b0;

      // A fresh error outranks a simultaneous clear request
      if (set_err) begin
        freq_err <= 1'b1;
      end else if (err_clr) begin
        freq_err <= 1'b0;
      end

      if (!en) begin
        state       <= IDLE;
        cyc_cnt     <= '0;
        edge_cnt    <= '0;
        good_streak <= 2'd0;
        lock        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cyc_cnt  <= '0;
            edge_cnt <= '0;
            state    <= ARM;
          end

          ARM: begin
            if (rise) begin
              cyc_cnt  <= '0;
              edge_cnt <= '0;
              state    <= MEAS;
            end else if (cyc_cnt == TO_LAST) begin
              cyc_cnt     <= '0;
              lock        <= 1'b0;
              good_streak <= 2'd0;
            end else begin
              cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
          end

          MEAS: begin
            if (win_close) begin
              // Closing rise also opens the next window back-to-back
              win_cnt   <= meas;
              win_valid <= 1'b1;
              cyc_cnt   <= '0;
              edge_cnt  <= '0;
              if (win_bad) begin
                lock        <= 1'b0;
                good_streak <= 2'd0;
              end else begin
                if (good_streak != 2'd2) begin
                  good_streak <= good_streak + 2'd1;
                end
                if (good_streak != 2'd0) begin
                  lock <= 1'b1;
                end
              end
            end else if (cyc_cnt == TO_LAST) begin
              state       <= ARM;
              cyc_cnt     <= '0;
              edge_cnt    <= '0;
              lock        <= 1'b0;
              good_streak <= 2'd0;
            end else begin
              if (rise) begin
                edge_cnt <= edge_cnt + EW'(1);
              end
              if (cyc_cnt != CNT_MAX) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef DIV_MON_MINMAX_EN
  logic [CNT_W-1:0] min_base;
  logic [CNT_W-1:0] max_base;

  // err_clr restarts tracking; a window closing in the same cycle still lands
  always_comb begin
    min_base = err_clr ? CNT_MAX : win_min;
    max_base = err_clr ? '0 : win_max;
  end

  // Running min/max of completed window lengths
  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_min <= CNT_MAX;
      win_max <= '0;
    end else if (win_close) begin
      win_min <= (meas < min_base) ? meas : min_base;
      win_max <= (meas > max_base) ? meas : max_base;
    end else begin
      win_min <= min_base;
      win_max <= max_base;
    end
  end
`else
  assign win_min = '0;
  assign win_max = '0;
`endif

endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor (default parameters, EXP=28).
// A pattern generator plays a list of per-window period shapes on clk_div_in;
// a table of windows with hand-computed results drives the main checks.
module tb_div_clk_monitor;

  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic             err_clr;
  logic             clk_div_in;
  logic [CNT_W-1:0] win_cnt;
  logic             win_valid;
  logic             freq_err;
  logic             lock;
  logic [CNT_W-1:0] win_min;
  logic [CNT_W-1:0] win_max;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   gen_on = 1'b0;
  logic man_val = 1'b0;
  int   grp_kind [64];

  typedef struct {
    int kind;
    bit clr_after;
    int exp_cnt;
    bit exp_err;
    bit exp_lock;
    int exp_min;
    int exp_max;
  } vec_t;

  vec_t tbl [11];

  div_clk_monitor #(
    .DIV_X2(7),
    .EDGES (8),
    .TOL   (2),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .err_clr   (err_clr),
    .clk_div_in(clk_div_in),
    .win_cnt   (win_cnt),
    .win_valid (win_valid),
    .freq_err  (freq_err),
    .lock      (lock),
    .win_min   (win_min),
    .win_max   (win_max)
  );

  always #5 clk = ~clk;

  // Period length (cycles) of period p within a group of 8, per shape kind
  function automatic int per_len(input int kind, input int p);
    case (kind)
      0: return (p % 2 == 0) ? 4 : 3;          // /3.5 : 28
      1: return 4;                              // /4   : 32
      2: return (p == 0 || p == 4) ? 4 : 3;     // 26
      3: return (p == 3 || p == 7) ? 3 : 4;     // 30
      4: return (p == 0) ? 4 : 3;               // 25
      5: return (p == 7) ? 3 : 4;               // 31
      default: return 3;                        // 24
    endcase
  endfunction

  function automatic int mm(input int v);
`ifdef DIV_MON_MINMAX_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Divided-clock generator: high 2 cycles then low for the rest of the period
  initial begin
    int g;
    int p;
    int pos;
    g = 0;
    p = 0;
    pos = 0;
    clk_div_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!gen_on) begin
        clk_div_in = man_val;
        g = 0;
        p = 0;
        pos = 0;
      end else begin
        clk_div_in = (pos < 2);
        pos++;
        if (pos >= per_len(grp_kind[g], p)) begin
          pos = 0;
          p++;
          if (p == 8) begin
            p = 0;
            if (g < 63) g++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input logic [CNT_W-1:0] act, input int exp);
    total++;
    if (act !== CNT_W'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (win_valid !== 1'b1 && n < maxc);
    chk1(name, win_valid, 1'b1);
  endtask

  initial begin
    int n;
    int last_cyc;
    bit early;
    bit vseen;

    rstn    = 1'b0;
    en      = 1'b0;
    err_clr = 1'b0;
    man_val = 1'b0;
    for (int i = 0; i < 64; i++) grp_kind[i] = 0;

    // ---------------- reset with toggling inputs ----------------
    for (int i = 0; i < 3; i++) begin
      en      = (i % 2 == 0);
      err_clr = (i % 2 == 1);
      man_val = (i % 2 == 0);
      step();
    end
    chkn("rst_win_cnt", win_cnt, 0);
    chk1("rst_win_valid", win_valid, 1'b0);
    chk1("rst_freq_err", freq_err, 1'b0);
    chk1("rst_lock", lock, 1'b0);
`ifdef DIV_MON_MINMAX_EN
    chkn("rst_win_min", win_min, 12'hFFF);
`else
    chkn("rst_win_min", win_min, 0);
`endif
    chkn("rst_win_max", win_max, 0);
    en      = 1'b0;
    err_clr = 1'b0;
    man_val = 1'b0;
    step();
    rstn = 1'b1;
    step();
    step();

    // ---------------- table-driven window stream ----------------
    tbl[0]  = '{0, 1'b0, 28, 1'b0, 1'b0, 28,  28};
    tbl[1]  = '{0, 1'b0, 28, 1'b0, 1'b1, 28,  28};
    tbl[2]  = '{1, 1'b0, 32, 1'b1, 1'b0, 28,  32};
    tbl[3]  = '{0, 1'b1, 28, 1'b1, 1'b0, 28,  32};
    tbl[4]  = '{2, 1'b0, 26, 1'b0, 1'b1, 26,  26};
    tbl[5]  = '{3, 1'b0, 30, 1'b0, 1'b1, 26,  30};
    tbl[6]  = '{4, 1'b1, 25, 1'b1, 1'b0, 25,  30};
    tbl[7]  = '{5, 1'b0, 31, 1'b1, 1'b0, 31,  31};
    tbl[8]  = '{6, 1'b0, 24, 1'b1, 1'b0, 24,  31};
    tbl[9]  = '{0, 1'b0, 28, 1'b1, 1'b0, 24,  31};
    tbl[10] = '{0, 1'b0, 28, 1'b1, 1'b1, 24,  31};
    for (int i = 0; i < 11; i++) grp_kind[i] = tbl[i].kind;

    en = 1'b1;
    gen_on = 1'b1;
    last_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      wait_valid("vec_valid", 100, n);
      $display("vec %0d: win_cnt=%0d freq_err=%0d lock=%0d min=%0d max=%0d gap=%0d",
               i, win_cnt, freq_err, lock, win_min, win_max, cyc - last_cyc);
      chkn("vec_win_cnt", win_cnt, tbl[i].exp_cnt);
      chk1("vec_freq_err", freq_err, tbl[i].exp_err);
      chk1("vec_lock", lock, tbl[i].exp_lock);
      chkn("vec_win_min", win_min, mm(tbl[i].exp_min));
      chkn("vec_win_max", win_max, mm(tbl[i].exp_max));
      if (i > 0) chk1("vec_gap", (cyc - last_cyc) == tbl[i].exp_cnt, 1'b1);
      last_cyc = cyc;
      err_clr = tbl[i].clr_after;
      step();
      chk1("vec_pulse_width", win_valid, 1'b0);
      if (tbl[i].clr_after) chk1("vec_err_clr", freq_err, 1'b0);
      err_clr = 1'b0;
    end

    // ---------------- err_clr coincident with a bad close ----------------
    gen_on = 1'b0;
    en = 1'b0;
    err_clr = 1'b1;
    step();
    step();
    step();
    err_clr = 1'b0;
    chk1("d_pre_clear", freq_err, 1'b0);
    for (int i = 0; i < 64; i++) grp_kind[i] = 0;
    grp_kind[1] = 1;
    grp_kind[3] = 1;
    en = 1'b1;
    gen_on = 1'b1;
    wait_valid("d_first_valid", 100, n);
    chkn("d_first_cnt", win_cnt, 28);
    chk1("d_first_err", freq_err, 1'b0);
    repeat (31) step();
    err_clr = 1'b1;
    step();
    $display("seq err_clr+bad: win_valid=%0d win_cnt=%0d freq_err=%0d", win_valid, win_cnt, freq_err);
    chk1("d_close_valid", win_valid, 1'b1);
    chkn("d_close_cnt", win_cnt, 32);
    chk1("d_err_wins", freq_err, 1'b1);
    step();
    chk1("d_clr_alone", freq_err, 1'b0);
    err_clr = 1'b0;
    wait_valid("d_third_valid", 100, n);
    chkn("d_third_cnt", win_cnt, 28);
    chk1("d_third_err", freq_err, 1'b0);
    wait_valid("d_fourth_valid", 100, n);
    chkn("d_fourth_cnt", win_cnt, 32);
    chk1("d_fourth_err", freq_err, 1'b1);

    // ---------------- en low for one cycle mid-window ----------------
    repeat (10) step();
    en = 1'b0;
    step();
    chkn("f_cnt_kept", win_cnt, 32);
    chk1("f_lock_low", lock, 1'b0);
    en = 1'b1;
    wait_valid("f_valid", 100, n);
    $display("seq en drop: cycles=%0d win_cnt=%0d freq_err=%0d", n, win_cnt, freq_err);
    chk1("f_no_partial", n >= 28, 1'b1);
    chkn("f_cnt", win_cnt, 28);
    chk1("f_err_kept", freq_err, 1'b1);

    // ---------------- rstn low for one cycle mid-window ----------------
    repeat (10) step();
    rstn = 1'b0;
    step();
    chkn("e_rst_cnt", win_cnt, 0);
    chk1("e_rst_err", freq_err, 1'b0);
    chk1("e_rst_valid", win_valid, 1'b0);
    rstn = 1'b1;
    wait_valid("e_valid", 100, n);
    $display("seq rst drop: cycles=%0d win_cnt=%0d", n, win_cnt);
    chk1("e_no_partial", n >= 28, 1'b1);
    chkn("e_cnt", win_cnt, 28);

    // ---------------- stuck-low divided clock ----------------
    gen_on = 1'b0;
    man_val = 1'b0;
    en = 1'b0;
    step();
    step();
    step();
    chk1("c_pre_err", freq_err, 1'b0);
    en = 1'b1;
    early = 1'b0;
    vseen = 1'b0;
    repeat (56) begin
      step();
      if (freq_err !== 1'b0) early = 1'b1;
      if (win_valid !== 1'b0) vseen = 1'b1;
    end
    chk1("c_no_early_err", early, 1'b0);
    step();
    $display("seq stuck: freq_err=%0d after 56 ARM cycles", freq_err);
    chk1("c_err_at_56", freq_err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk1("c_err_cleared", freq_err, 1'b0);
    early = 1'b0;
    repeat (54) begin
      step();
      if (freq_err !== 1'b0) early = 1'b1;
      if (win_valid !== 1'b0) vseen = 1'b1;
    end
    chk1("c_no_early_err2", early, 1'b0);
    step();
    chk1("c_err_again", freq_err, 1'b1);
    chk1("c_no_valid", vseen, 1'b0);
    chk1("c_lock_low", lock, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
